// File: rtl/control_sequencer_if.sv
// control_sequencer_if
//   Bundles the control unit's connection to the Datapath.
//   master : control unit side (reads IR/CON_FF/stop, drives every strobe).
//   slave  : Datapath side (drives IR/CON_FF/stop, receives every strobe).
//   Signals
//     IR, CON_FF, stop            Datapath/external -> control unit
//     *out (10)                   bus-drive selects
//     *in  (14)                   register load enables
//     Gra, Grb, Grc               register-field selects
//     IncPC, Read, Write          PC increment, memory strobes
//     alu_op [OPW-1:0]            ALU operation code
//     Run                         1 while an instruction is executing
interface control_sequencer_if #(
  parameter int OPW = 5
);
  logic [31:0]    IR;
  logic           CON_FF;
  logic           stop;

  logic           PCout, Zhighout, Zlowout, MDRout, HIout, LOout;
  logic           InPortout, Cout, BAout, Rout;

  logic           PCin, MARin, MDRin, IRin, Yin, HIin, LOin;
  logic           Zhighin, Zlowin, OutPortin, CONin, Rin;
  logic           InPortin, Cin;

  logic           Gra, Grb, Grc, IncPC, Read, Write;
  logic [OPW-1:0] alu_op;
  logic           Run;

  modport master (
    input  IR, CON_FF, stop,
    output PCout, Zhighout, Zlowout, MDRout, HIout, LOout,
           InPortout, Cout, BAout, Rout,
           PCin, MARin, MDRin, IRin, Yin, HIin, LOin,
           Zhighin, Zlowin, OutPortin, CONin, Rin, InPortin, Cin,
           Gra, Grb, Grc, IncPC, Read, Write, alu_op, Run
  );

  modport slave (
    output IR, CON_FF, stop,
    input  PCout, Zhighout, Zlowout, MDRout, HIout, LOout,
           InPortout, Cout, BAout, Rout,
           PCin, MARin, MDRin, IRin, Yin, HIin, LOin,
           Zhighin, Zlowin, OutPortin, CONin, Rin, InPortin, Cin,
           Gra, Grb, Grc, IncPC, Read, Write, alu_op, Run
  );
endinterface

// File: rtl/control_sequencer.sv
// control_sequencer
//   Hardwired Mini-SRC control unit. A fixed three-step fetch (T0-T2) is
//   followed by opcode-dependent execute steps (T3-T7). Every strobe is a
//   Moore decode of (step, opcode); one step per clock.
//   Ports
//     clock  : single clock, rising edge
//     clear  : synchronous active-low reset
//     bus    : control_sequencer_if.master (IR/CON_FF/stop in, strobes out)
module control_sequencer #(
  parameter int OPW    = 5,
  parameter int NSTEPS = 8
) (
  input  logic                 clock,
  input  logic                 clear,
  control_sequencer_if.master  bus
);

  localparam int STEP_W = $clog2(NSTEPS);

  localparam logic [OPW-1:0] ALU_ADD = OPW'(3);

  // T-states share their encoding with the step index so the low bits
  // can be compared directly against an instruction's last step.
  typedef enum logic [3:0] {
    S_T0    = 4'd0,
    S_T1    = 4'd1,
    S_T2    = 4'd2,
    S_T3    = 4'd3,
    S_T4    = 4'd4,
    S_T5    = 4'd5,
    S_T6    = 4'd6,
    S_T7    = 4'd7,
    S_RESET = 4'd8,
    S_HALT  = 4'd9
  } state_t;

  typedef enum logic [3:0] {
    C_NONE, C_LD, C_LDI, C_ST, C_ALU, C_IMM, C_MULDIV, C_UNARY,
    C_BR, C_JR, C_IN, C_OUT, C_MFHI, C_MFLO, C_HALT
  } op_class_t;

  state_t          state, next_state;
  logic [OPW-1:0]  op;
  op_class_t       cls;
  logic            at_last;
  logic            unused_ir;

  assign op        = bus.IR[31 -: OPW];
  assign unused_ir = ^bus.IR[31-OPW:0];

  function automatic op_class_t classify(input logic [OPW-1:0] o);
    op_class_t c;
    c = C_NONE;
    if      (o == OPW'(0))                       c = C_LD;
    else if (o == OPW'(1))                       c = C_LDI;
    else if (o == OPW'(2))                       c = C_ST;
    else if (o >= OPW'(3)  && o <= OPW'(11))     c = C_ALU;
    else if (o >= OPW'(12) && o <= OPW'(14))     c = C_IMM;
    else if (o == OPW'(15) || o == OPW'(16))     c = C_MULDIV;
    else if (o == OPW'(17) || o == OPW'(18))     c = C_UNARY;
    else if (o == OPW'(19))                      c = C_BR;
    else if (o == OPW'(20))                      c = C_JR;
    else if (o == OPW'(22))                      c = C_IN;
    else if (o == OPW'(23))                      c = C_OUT;
    else if (o == OPW'(24))                      c = C_MFHI;
    else if (o == OPW'(25))                      c = C_MFLO;
    else if (o == OPW'(27))                      c = C_HALT;
    return c;
  endfunction

  // Index of the final step of each instruction class; T2 means the
  // instruction has no execute phase (nop, jal and unassigned opcodes).
  function automatic logic [STEP_W-1:0] last_step(input op_class_t c);
    logic [STEP_W-1:0] s;
    case (c)
      C_LD, C_ST:                s = STEP_W'(7);
      C_MULDIV, C_BR:            s = STEP_W'(6);
      C_LDI, C_ALU, C_IMM:       s = STEP_W'(5);
      C_UNARY:                   s = STEP_W'(4);
      C_JR, C_IN, C_OUT,
      C_MFHI, C_MFLO:            s = STEP_W'(3);
      default:                   s = STEP_W'(2);
    endcase
    return s;
  endfunction

  assign cls     = classify(op);
  assign at_last = (state <= S_T7) && (state[STEP_W-1:0] == last_step(cls));

  always_ff @(posedge clock) begin
    if (!clear) state <= S_RESET;
    else        state <= next_state;
  end

  always_comb begin
    next_state    = state;
    bus.PCout     = 1'b0;
    bus.Zhighout  = 1'b0;
    bus.Zlowout   = 1'b0;
    bus.MDRout    = 1'b0;
    bus.HIout     = 1'b0;
    bus.LOout     = 1'b0;
    bus.InPortout = 1'b0;
    bus.Cout      = 1'b0;
    bus.BAout     = 1'b0;
    bus.Rout      = 1'b0;
    bus.PCin      = 1'b0;
    bus.MARin     = 1'b0;
    bus.MDRin     = 1'b0;
    bus.IRin      = 1'b0;
    bus.Yin       = 1'b0;
    bus.HIin      = 1'b0;
    bus.LOin      = 1'b0;
    bus.Zhighin   = 1'b0;
    bus.Zlowin    = 1'b0;
    bus.OutPortin = 1'b0;
    bus.CONin     = 1'b0;
    bus.Rin       = 1'b0;
    bus.InPortin  = 1'b0;
    bus.Cin       = 1'b0;
    bus.Gra       = 1'b0;
    bus.Grb       = 1'b0;
    bus.Grc       = 1'b0;
    bus.IncPC     = 1'b0;
    bus.Read      = 1'b0;
    bus.Write     = 1'b0;
    bus.alu_op    = '0;
    bus.Run       = 1'b0;

    case (state)
      S_RESET: next_state = S_T0;
      S_HALT:  next_state = S_HALT;
      default: begin
        bus.Run = 1'b1;
        // The halt opcode is recognised at the end of fetch; stop is only
        // honoured once the current instruction has finished.
        if (state == S_T2 && cls == C_HALT) next_state = S_HALT;
        else if (at_last)                   next_state = bus.stop ? S_HALT : S_T0;
        else                                next_state = state_t'(state + 4'd1);
      end
    endcase

    case (state)
      S_T0: begin
        bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1; bus.Zlowin = 1'b1;
      end
      S_T1: begin
        bus.Zlowout = 1'b1; bus.PCin = 1'b1; bus.Read = 1'b1; bus.MDRin = 1'b1;
      end
      S_T2: begin
        bus.MDRout = 1'b1; bus.IRin = 1'b1;
      end
      S_T3: begin
        case (cls)
          C_LD, C_LDI, C_ST: begin
            bus.Grb = 1'b1; bus.BAout = 1'b1; bus.Yin = 1'b1;
          end
          C_ALU, C_IMM: begin
            bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1;
          end
          C_MULDIV: begin
            bus.Gra = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1;
          end
          C_UNARY: begin
            bus.Grb = 1'b1; bus.Rout = 1'b1; bus.alu_op = op; bus.Zlowin = 1'b1;
          end
          C_BR: begin
            bus.Gra = 1'b1; bus.Rout = 1'b1; bus.CONin = 1'b1;
          end
          C_JR: begin
            bus.Gra = 1'b1; bus.Rout = 1'b1; bus.PCin = 1'b1;
          end
          C_IN: begin
            bus.InPortout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
          end
          C_OUT: begin
            bus.Gra = 1'b1; bus.Rout = 1'b1; bus.OutPortin = 1'b1;
          end
          C_MFHI: begin
            bus.HIout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
          end
          C_MFLO: begin
            bus.LOout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
          end
          default: ;
        endcase
      end
      S_T4: begin
        case (cls)
          C_LD, C_LDI, C_ST: begin
            bus.Cout = 1'b1; bus.alu_op = ALU_ADD; bus.Zlowin = 1'b1;
          end
          C_ALU: begin
            bus.Grc = 1'b1; bus.Rout = 1'b1; bus.alu_op = op; bus.Zlowin = 1'b1;
          end
          C_IMM: begin
            bus.Cout = 1'b1; bus.alu_op = op; bus.Zlowin = 1'b1;
          end
          C_MULDIV: begin
            bus.Grb = 1'b1; bus.Rout = 1'b1; bus.alu_op = op;
            bus.Zhighin = 1'b1; bus.Zlowin = 1'b1;
          end
          C_UNARY: begin
            bus.Zlowout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
          end
          C_BR: begin
            bus.PCout = 1'b1; bus.Yin = 1'b1;
          end
          default: ;
        endcase
      end
      S_T5: begin
        case (cls)
          C_LD, C_ST: begin
            bus.Zlowout = 1'b1; bus.MARin = 1'b1;
          end
          C_LDI, C_ALU, C_IMM: begin
            bus.Zlowout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
          end
          C_MULDIV: begin
            bus.Zlowout = 1'b1; bus.LOin = 1'b1;
          end
          C_BR: begin
            bus.Cout = 1'b1; bus.alu_op = ALU_ADD; bus.Zlowin = 1'b1;
          end
          default: ;
        endcase
      end
      S_T6: begin
        case (cls)
          C_LD: begin
            bus.Read = 1'b1; bus.MDRin = 1'b1;
          end
          C_ST: begin
            bus.Gra = 1'b1; bus.Rout = 1'b1; bus.MDRin = 1'b1;
          end
          C_MULDIV: begin
            bus.Zhighout = 1'b1; bus.HIin = 1'b1;
          end
          C_BR: begin
            // Branch target is committed only when the condition flop is set.
            bus.Zlowout = 1'b1; bus.PCin = bus.CON_FF;
          end
          default: ;
        endcase
      end
      S_T7: begin
        case (cls)
          C_LD: begin
            bus.MDRout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
          end
          C_ST: bus.Write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer
//   Directed stimulus for control_sequencer. Each stimulus cycle queues the
//   hand-written strobe vector expected during that cycle; a monitor on the
//   falling edge pops and compares it with the DUT outputs.
module tb_control_sequencer;

  typedef logic [35:0] vec_t;

  localparam vec_t PCOUT     = 36'h1 << 0;
  localparam vec_t ZHIGHOUT  = 36'h1 << 1;
  localparam vec_t ZLOWOUT   = 36'h1 << 2;
  localparam vec_t MDROUT    = 36'h1 << 3;
  localparam vec_t HIOUT     = 36'h1 << 4;
  localparam vec_t LOOUT     = 36'h1 << 5;
  localparam vec_t INPORTOUT = 36'h1 << 6;
  localparam vec_t COUT      = 36'h1 << 7;
  localparam vec_t BAOUT     = 36'h1 << 8;
  localparam vec_t ROUT      = 36'h1 << 9;
  localparam vec_t PCIN      = 36'h1 << 10;
  localparam vec_t MARIN     = 36'h1 << 11;
  localparam vec_t MDRIN     = 36'h1 << 12;
  localparam vec_t IRIN      = 36'h1 << 13;
  localparam vec_t YIN       = 36'h1 << 14;
  localparam vec_t HIIN      = 36'h1 << 15;
  localparam vec_t LOIN      = 36'h1 << 16;
  localparam vec_t ZHIGHIN   = 36'h1 << 17;
  localparam vec_t ZLOWIN    = 36'h1 << 18;
  localparam vec_t OUTPORTIN = 36'h1 << 19;
  localparam vec_t CONIN     = 36'h1 << 20;
  localparam vec_t RIN       = 36'h1 << 21;
  localparam vec_t GRA       = 36'h1 << 22;
  localparam vec_t GRB       = 36'h1 << 23;
  localparam vec_t GRC       = 36'h1 << 24;
  localparam vec_t INCPC     = 36'h1 << 25;
  localparam vec_t READ      = 36'h1 << 26;
  localparam vec_t WRITE     = 36'h1 << 27;
  localparam vec_t RUN       = 36'h1 << 30;
  localparam vec_t ADD       = {5'b00011, 31'b0};

  localparam vec_t F0 = RUN | PCOUT | MARIN | INCPC | ZLOWIN;
  localparam vec_t F1 = RUN | ZLOWOUT | PCIN | READ | MDRIN;
  localparam vec_t F2 = RUN | MDROUT | IRIN;

  logic clk;
  logic clear;
  int   n_cmp;
  int   n_bad;
  vec_t  exp_q[$];
  string name_q[$];

  control_sequencer_if #(.OPW(5)) bus ();

  control_sequencer #(.OPW(5), .NSTEPS(8)) dut (
    .clock (clk),
    .clear (clear),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t dut_vec();
    vec_t v;
    v = '0;
    v[0]  = bus.PCout;     v[1]  = bus.Zhighout; v[2]  = bus.Zlowout;
    v[3]  = bus.MDRout;    v[4]  = bus.HIout;    v[5]  = bus.LOout;
    v[6]  = bus.InPortout; v[7]  = bus.Cout;     v[8]  = bus.BAout;
    v[9]  = bus.Rout;      v[10] = bus.PCin;     v[11] = bus.MARin;
    v[12] = bus.MDRin;     v[13] = bus.IRin;     v[14] = bus.Yin;
    v[15] = bus.HIin;      v[16] = bus.LOin;     v[17] = bus.Zhighin;
    v[18] = bus.Zlowin;    v[19] = bus.OutPortin; v[20] = bus.CONin;
    v[21] = bus.Rin;       v[22] = bus.Gra;      v[23] = bus.Grb;
    v[24] = bus.Grc;       v[25] = bus.IncPC;    v[26] = bus.Read;
    v[27] = bus.Write;     v[28] = bus.InPortin; v[29] = bus.Cin;
    v[30] = bus.Run;       v[35:31] = bus.alu_op;
    return v;
  endfunction

  // Monitor: one expected vector per presented cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      vec_t  e;
      vec_t  a;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = dut_vec();
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL %s: got %09h expected %09h", nm, a, e);
      end
    end
  end

  task automatic cyc(input vec_t e, input string nm);
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  // IR holds unrelated words during T0/T1 to show they do not leak into
  // the strobes; the real instruction is presented from T2 on.
  task automatic fetch(input logic [31:0] ir, input string tag);
    bus.IR = 32'hD800_0000;
    cyc(F0, {tag, " T0"});
    bus.IR = 32'h5555_5555;
    cyc(F1, {tag, " T1"});
    bus.IR = ir;
    cyc(F2, {tag, " T2"});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    clear      = 1'b0;
    bus.IR     = 32'h0;
    bus.CON_FF = 1'b0;
    bus.stop   = 1'b0;
    @(posedge clk);
    #1;

    // Reset held two cycles, then released
    cyc('0, "reset c0");
    cyc('0, "reset c1");
    clear = 1'b1;
    cyc('0, "reset release");

    // ld: 8 cycles T0..T7 then T0
    fetch(32'h0088_0000, "ld");
    cyc(RUN | GRB | BAOUT | YIN,        "ld T3");
    cyc(RUN | COUT | ADD | ZLOWIN,      "ld T4");
    cyc(RUN | ZLOWOUT | MARIN,          "ld T5");
    cyc(RUN | READ | MDRIN,             "ld T6");
    cyc(RUN | MDROUT | GRA | RIN,       "ld T7");

    // add: 6 cycles
    fetch(32'h1800_0000, "add");
    cyc(RUN | GRB | ROUT | YIN,         "add T3");
    cyc(RUN | GRC | ROUT | ADD | ZLOWIN, "add T4");
    cyc(RUN | ZLOWOUT | GRA | RIN,      "add T5");

    // br, condition false
    bus.CON_FF = 1'b0;
    fetch(32'h9800_0000, "br0");
    cyc(RUN | GRA | ROUT | CONIN,       "br0 T3");
    cyc(RUN | PCOUT | YIN,              "br0 T4");
    cyc(RUN | COUT | ADD | ZLOWIN,      "br0 T5");
    cyc(RUN | ZLOWOUT,                  "br0 T6");

    // br, condition true
    bus.CON_FF = 1'b1;
    fetch(32'h9800_0000, "br1");
    cyc(RUN | GRA | ROUT | CONIN,       "br1 T3");
    cyc(RUN | PCOUT | YIN,              "br1 T4");
    cyc(RUN | COUT | ADD | ZLOWIN,      "br1 T5");
    cyc(RUN | ZLOWOUT | PCIN,           "br1 T6");
    bus.CON_FF = 1'b0;

    // jr: 4 cycles
    fetch(32'hA000_0000, "jr");
    cyc(RUN | GRA | ROUT | PCIN,        "jr T3");

    // nop: 3 cycles
    fetch(32'hD000_0000, "nop");

    // halt: stays quiet until clear
    fetch(32'hD800_0000, "halt");
    for (int i = 0; i < 20; i++) cyc('0, "halt idle");
    clear = 1'b0;
    cyc('0, "halt clear lo");
    clear = 1'b1;
    cyc('0, "halt reset");

    // st aborted by clear during T5: Write must never appear
    fetch(32'h1000_0000, "st");
    cyc(RUN | GRB | BAOUT | YIN,        "st T3");
    cyc(RUN | COUT | ADD | ZLOWIN,      "st T4");
    clear = 1'b0;
    cyc(RUN | ZLOWOUT | MARIN,          "st T5");
    clear = 1'b1;
    cyc('0, "st aborted reset");

    // ldi: stop mid-instruction is ignored, stop at last step halts
    fetch(32'h0800_0000, "ldi");
    bus.stop = 1'b1;
    cyc(RUN | GRB | BAOUT | YIN,        "ldi T3");
    bus.stop = 1'b0;
    cyc(RUN | COUT | ADD | ZLOWIN,      "ldi T4");
    bus.stop = 1'b1;
    cyc(RUN | ZLOWOUT | GRA | RIN,      "ldi T5");
    bus.stop = 1'b0;
    cyc('0, "ldi halted c0");
    cyc('0, "ldi halted c1");

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d vectors left, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
